vend_change_dispenser: RTL and testbench

Payout side of the vending machine: converts a credit/price pair into a paced train of coin-release pulses toward the coin hopper, one coin per unit of change, each confirmed by the hopper's drop sensor. It sits beside the credit (Moore) and product (Mealy) FSMs on the prescaled internal clock. It is started by the dispense event and refunds the full credit when the credit is insufficient.

---
 rtl/vend_pkg.sv | 34 +++
 rtl/vend_change_dispenser_if.sv | 31 +++
 rtl/vend_timer.sv | 37 +++
 rtl/vend_change_dispenser.sv | 169 ++++++++++++++++
 tb/tb_vend_change_dispenser.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// ----------------------------------------------------------------------------
// vend_pkg
// Shared definitions for the vending machine control slice: payout FSM state
// encoding, the default credit width, and the change computation used by both
// the change dispenser and the credit FSM.
// ----------------------------------------------------------------------------
package vend_pkg;

    // Default width of credit, price and change values.
    localparam int CREDIT_W = 3;

    // Working width of calc_change; callers zero-extend into it and truncate
    // the result back to their own CREDIT_W.
    localparam int CALC_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        PULSE,
        WAIT_ACK,
        GAP,
        DONE,
        FAULT
    } state_t;

    // Insufficient credit refunds everything; otherwise pay back the surplus.
    // The result never exceeds credit, so it cannot wrap.
    function automatic logic [CALC_W-1:0] calc_change(
        input logic [CALC_W-1:0] credit,
        input logic [CALC_W-1:0] price
    );
        return (credit >= price) ? (credit - price) : credit;
    endfunction

endpackage

// File: rtl/vend_change_dispenser_if.sv
// ----------------------------------------------------------------------------
// vend_change_dispenser_if
// Request and hopper signals of the change dispenser.
//   master : requester/hopper side (drives start, credit, price, clear,
//            coin_ack; observes coin_out, busy, done, fault, change_left)
//   slave  : the dispenser itself
// ----------------------------------------------------------------------------
interface vend_change_dispenser_if #(
    parameter int CREDIT_W = vend_pkg::CREDIT_W
);
    logic                start;
    logic [CREDIT_W-1:0] credit;
    logic [CREDIT_W-1:0] price;
    logic                clear;
    logic                coin_ack;
    logic                coin_out;
    logic                busy;
    logic                done;
    logic                fault;
    logic [CREDIT_W-1:0] change_left;

    modport master (
        output start, credit, price, clear, coin_ack,
        input  coin_out, busy, done, fault, change_left
    );

    modport slave (
        input  start, credit, price, clear, coin_ack,
        output coin_out, busy, done, fault, change_left
    );
endinterface

// File: rtl/vend_timer.sv
// ----------------------------------------------------------------------------
// vend_timer
// Loadable down-counter shared by the PULSE, WAIT_ACK and GAP phases.
// A load of N makes `expired` rise on the N-th cycle after the load edge, so
// a state that loads N on entry and leaves on `expired` lasts N cycles.
//   clk, reset : clock, asynchronous active-high reset
//   load       : load `load_val` on this edge (wins over counting)
//   load_val   : cycle count to run
//   expired    : high during the last counted cycle
// ----------------------------------------------------------------------------
module vend_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count;

    // NOTE: sequential state is written with <= only, so every flop samples
    // the pre-edge value of its neighbours regardless of process order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expired = (count == W'(1));

endmodule

// File: rtl/vend_change_dispenser.sv
// ----------------------------------------------------------------------------
// vend_change_dispenser
// Pays out change as a paced train of coin_out pulses, one per coin, each
// confirmed by the hopper's coin_ack. Faults if a coin is never confirmed.
//   clk, reset  : prescaled clock, asynchronous active-high reset
//   bus.start   : one-cycle payout request (IDLE only), samples credit/price
//   bus.clear   : leaves FAULT
//   bus.coin_ack: hopper drop sensor
//   bus.coin_out: coin-release strobe, PULSE_CYCLES long per coin
//   bus.busy / bus.done / bus.fault : status, decoded from registered state
//   bus.change_left : coins still owed (held in FAULT)
// ----------------------------------------------------------------------------
module vend_change_dispenser
    import vend_pkg::*;
#(
    parameter int CREDIT_W     = vend_pkg::CREDIT_W,
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 4,
    parameter int ACK_TIMEOUT  = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    vend_change_dispenser_if.slave  bus
);

    localparam int TMR_MAX_PG = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TMR_MAX    = (ACK_TIMEOUT > TMR_MAX_PG) ? ACK_TIMEOUT : TMR_MAX_PG;
    localparam int TMR_W      = $clog2(TMR_MAX + 1);

    state_t              state;
    state_t              state_next;
    logic [CREDIT_W-1:0] change_left;
    logic [CREDIT_W-1:0] start_change;
    logic                ack_seen;
    logic                accept;
    logic                load_change;
    logic                clear_change;
    logic                tmr_load;
    logic [TMR_W-1:0]    tmr_val;
    logic                tmr_expired;

    assign start_change = CREDIT_W'(calc_change(CALC_W'(bus.credit), CALC_W'(bus.price)));

    vend_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Each timed state loads the shared timer on entry.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves a signal unassigned and no latch is inferred.
        state_next   = state;
        tmr_load     = 1'b0;
        tmr_val      = '0;
        accept       = 1'b0;
        load_change  = 1'b0;
        clear_change = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    load_change = 1'b1;
                    if (start_change == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next = PULSE;
                        tmr_load   = 1'b1;
                        tmr_val    = TMR_W'(PULSE_CYCLES);
                    end
                end
            end
            PULSE: begin
                // An ack on the final pulse cycle counts as seen in PULSE.
                if (tmr_expired) begin
                    if (ack_seen || bus.coin_ack) begin
                        accept = 1'b1;
                    end else begin
                        state_next = WAIT_ACK;
                        tmr_load   = 1'b1;
                        tmr_val    = TMR_W'(ACK_TIMEOUT);
                    end
                end
            end
            WAIT_ACK: begin
                // Ack wins over a simultaneous timeout.
                if (bus.coin_ack) begin
                    accept = 1'b1;
                end else if (tmr_expired) begin
                    state_next = FAULT;
                end
            end
            GAP: begin
                if (tmr_expired) begin
                    state_next = PULSE;
                    tmr_load   = 1'b1;
                    tmr_val    = TMR_W'(PULSE_CYCLES);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            FAULT: begin
                if (bus.clear) begin
                    state_next   = IDLE;
                    clear_change = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (accept) begin
            if (change_left == CREDIT_W'(1)) begin
                state_next = DONE;
            end else begin
                state_next = GAP;
                tmr_load   = 1'b1;
                tmr_val    = TMR_W'(GAP_CYCLES);
            end
        end
    end

    // Coin bookkeeping. ack_seen only lives within one PULSE visit, so a long
    // ack never counts for more than one coin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            change_left <= '0;
            ack_seen    <= 1'b0;
        end else begin
            if (load_change) begin
                change_left <= start_change;
            end else if (accept) begin
                change_left <= change_left - CREDIT_W'(1);
            end else if (clear_change) begin
                change_left <= '0;
            end

            if (accept || state != PULSE) begin
                ack_seen <= 1'b0;
            end else if (bus.coin_ack) begin
                ack_seen <= 1'b1;
            end
        end
    end

    // Outputs: pure decode of registered state and counters.
    always_comb begin
        bus.coin_out    = (state == PULSE);
        bus.busy        = (state != IDLE);
        bus.done        = (state == DONE);
        bus.fault       = (state == FAULT);
        bus.change_left = change_left;
    end

endmodule

// File: tb/tb_vend_change_dispenser.sv
// ----------------------------------------------------------------------------
// tb_vend_change_dispenser
// For each payout the bench lays out the expected output timeline from the
// payout rules (pulse, optional ack wait, gap, done, fault) together with the
// coin_ack / start / clear stimulus, then replays the stimulus cycle by cycle
// and compares {coin_out, busy, done, fault, change_left} after every edge.
// ----------------------------------------------------------------------------
module tb_vend_change_dispenser;

    localparam int CW   = 3;
    localparam int P    = 4;
    localparam int G    = 4;
    localparam int T    = 15;
    localparam int MAXC = 320;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vend_change_dispenser_if #(.CREDIT_W(CW)) bus ();

    vend_change_dispenser #(
        .CREDIT_W     (CW),
        .PULSE_CYCLES (P),
        .GAP_CYCLES   (G),
        .ACK_TIMEOUT  (T)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Expected outputs after edge t, and inputs sampled at edge t.
    logic [6:0] exp_v    [MAXC];
    logic       in_start [MAXC];
    logic       in_ack   [MAXC];
    logic       in_clear [MAXC];
    int         n_cyc;
    int         cur_credit;
    int         cur_price;

    // Per-coin ack plan: kind 0 = ack arg cycles into the pulse, kind 1 = ack
    // on wait cycle arg (1-based), kind 2 = never acked. len = ack length.
    int plan_kind [8];
    int plan_arg  [8];
    int plan_len  [8];

    function automatic logic [6:0] pack(bit c, bit b, bit d, bit f, int cl);
        return {c, b, d, f, 3'(cl)};
    endfunction

    task automatic clear_arrays();
        for (int i = 0; i < MAXC; i++) begin
            exp_v[i]    = '0;
            in_start[i] = 1'b0;
            in_ack[i]   = 1'b0;
            in_clear[i] = 1'b0;
        end
        n_cyc = 0;
    endtask

    task automatic put(input logic [6:0] v);
        exp_v[n_cyc] = v;
        n_cyc++;
    endtask

    task automatic set_ack(input int from, input int len);
        for (int j = 0; j < len; j++)
            if (from + j < MAXC) in_ack[from + j] = 1'b1;
    endtask

    // Lay out the timeline for one payout started at edge 0.
    task automatic build(input int credit, input int price, input bit noise);
        int ch;
        int left;
        int ps;
        bit faulted;
        ch         = (credit >= price) ? credit - price : credit;
        faulted    = 1'b0;
        cur_credit = credit;
        cur_price  = price;
        clear_arrays();
        in_start[0] = 1'b1;
        if (ch == 0) begin
            put(pack(0, 1, 1, 0, 0));
        end else begin
            for (int i = 0; i < ch && !faulted; i++) begin
                left = ch - i;
                ps   = n_cyc;
                for (int j = 0; j < P; j++) put(pack(1, 1, 0, 0, left));
                case (plan_kind[i])
                    0: set_ack(ps + plan_arg[i] + 1, plan_len[i]);
                    1: begin
                        for (int k = 1; k <= plan_arg[i]; k++) begin
                            if (k == plan_arg[i]) set_ack(n_cyc + 1, plan_len[i]);
                            put(pack(0, 1, 0, 0, left));
                        end
                    end
                    default: begin
                        for (int k = 0; k < T; k++) put(pack(0, 1, 0, 0, left));
                        for (int k = 0; k < 3; k++) put(pack(0, 1, 0, 1, left));
                        in_clear[n_cyc] = 1'b1;
                        faulted = 1'b1;
                    end
                endcase
                if (!faulted) begin
                    if (left == 1) put(pack(0, 1, 1, 0, 0));
                    else for (int j = 0; j < G; j++) put(pack(0, 1, 0, 0, left - 1));
                end
            end
        end
        for (int j = 0; j < 4; j++) put(pack(0, 0, 0, 0, 0));
        // Stray start while busy and stray clear outside FAULT must be ignored.
        if (noise) begin
            for (int t = 1; t < n_cyc; t++) begin
                if (exp_v[t-1][5] && ($urandom % 4 == 0)) in_start[t] = 1'b1;
                if (!exp_v[t-1][3] && ($urandom % 5 == 0)) in_clear[t] = 1'b1;
            end
        end
    endtask

    task automatic run(input string name);
        logic [6:0] obs;
        for (int t = 0; t < n_cyc; t++) begin
            bus.start    = in_start[t];
            bus.coin_ack = in_ack[t];
            bus.clear    = in_clear[t];
            if (t == 0) begin
                bus.credit = 3'(cur_credit);
                bus.price  = 3'(cur_price);
            end else begin
                bus.credit = 3'($urandom);
                bus.price  = 3'($urandom);
            end
            @(posedge clk);
            #1;
            obs = {bus.coin_out, bus.busy, bus.done, bus.fault, bus.change_left};
            checks++;
            if (obs !== exp_v[t]) begin
                failures++;
                $display("FAIL %s cycle %0d: got {coin,busy,done,fault,left}=%b want %b",
                         name, t, obs, exp_v[t]);
            end
        end
        bus.start    = 1'b0;
        bus.coin_ack = 1'b0;
        bus.clear    = 1'b0;
    endtask

    task automatic rand_plans(input bit allow_fault);
        int r;
        for (int i = 0; i < 8; i++) begin
            r = int'($urandom % 8);
            if (r < 4) begin
                plan_kind[i] = 0;
                plan_arg[i]  = int'($urandom_range(0, P - 2));
                plan_len[i]  = int'($urandom_range(1, P - plan_arg[i] + G));
            end else if (r < 7 || !allow_fault) begin
                plan_kind[i] = 1;
                plan_arg[i]  = int'($urandom_range(1, T));
                plan_len[i]  = int'($urandom_range(1, G + 1));
            end else begin
                plan_kind[i] = 2;
                plan_arg[i]  = 0;
                plan_len[i]  = 0;
            end
        end
    endtask

    task automatic set_plan(input int i, input int kind, input int arg, input int len);
        plan_kind[i] = kind;
        plan_arg[i]  = arg;
        plan_len[i]  = len;
    endtask

    task automatic check_idle_outputs(input string name);
        logic [6:0] obs;
        obs = {bus.coin_out, bus.busy, bus.done, bus.fault, bus.change_left};
        checks++;
        if (obs !== 7'b0) begin
            failures++;
            $display("FAIL %s: got {coin,busy,done,fault,left}=%b want 0000000", name, obs);
        end
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.credit   = '0;
        bus.price    = '0;
        bus.clear    = 1'b0;
        bus.coin_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset_held");
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        check_idle_outputs("reset_released");
    endtask

    task automatic test_basic_change();
        set_plan(0, 0, 1, 2);
        set_plan(1, 0, 1, 2);
        build(5, 3, 1'b0);
        run("basic_5_3");
    endtask

    task automatic test_refund();
        set_plan(0, 0, 0, 1);
        set_plan(1, 0, 2, 1);
        build(2, 6, 1'b0);
        run("refund_2_6");
    endtask

    task automatic test_zero_change();
        build(4, 4, 1'b0);
        run("zero_4_4");
        build(0, 7, 1'b0);
        run("zero_0_7");
    endtask

    task automatic test_fault();
        set_plan(0, 0, 1, 1);
        set_plan(1, 2, 0, 0);
        build(3, 0, 1'b0);
        run("fault_3_0");
        set_plan(0, 1, 3, 2);
        build(1, 0, 1'b0);
        run("after_fault_restart");
    endtask

    task automatic test_ack_widths();
        set_plan(0, 0, 0, 1);
        set_plan(1, 0, 1, 6);
        set_plan(2, 1, T, 1);
        set_plan(3, 1, 1, G + 1);
        build(4, 0, 1'b0);
        run("ack_widths");
    endtask

    task automatic test_start_ignored();
        rand_plans(1'b0);
        build(6, 1, 1'b1);
        run("start_ignored");
        set_plan(0, 0, 0, 1);
        set_plan(1, 2, 0, 0);
        build(7, 5, 1'b1);
        run("start_clear_noise_fault");
    endtask

    task automatic test_reset_mid_pulse();
        logic [6:0] obs;
        bus.credit = 3'd6;
        bus.price  = 3'd0;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        obs = {bus.coin_out, bus.busy, bus.done, bus.fault, bus.change_left};
        checks++;
        if (obs !== 7'b1100110) begin
            failures++;
            $display("FAIL mid_reset_pulse_started: got %b want 1100110", obs);
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_idle_outputs("mid_reset_immediate");
        @(posedge clk);
        #1;
        check_idle_outputs("mid_reset_held");
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        check_idle_outputs("mid_reset_released");
        rand_plans(1'b0);
        build(3, 1, 1'b0);
        run("after_mid_reset");
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            rand_plans(1'b1);
            build(int'($urandom % 8), int'($urandom % 8), 1'($urandom % 2));
            run($sformatf("random_%0d", it));
        end
    endtask

    initial begin
        test_reset();
        test_basic_change();
        test_refund();
        test_zero_change();
        test_fault();
        test_ack_widths();
        test_start_ignored();
        test_reset_mid_pulse();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
